mul_sequencer: RTL
==================

MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 SHALL expose parameter: none; operand width fixed 32, product width 64.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  1  request present.
REQ-005 req_ready  out  1  sequencer can accept a request.
REQ-006 req_src1  in  32  operand A.
REQ-007 req_src2  in  32  operand B.
REQ-008 req_src1_signed  in  1  A is two's-complement.
REQ-009 req_src2_signed  in  1  B is two's-complement.
REQ-010 flush  in  1  cancel in-flight operation, no response.
REQ-011 rsp_valid  out  1  result available.
REQ-012 rsp_ready  in  1  consumer takes result.
REQ-013 rsp_result  out  64  full product A*B.
REQ-014 busy  out  1  high in any state other than IDLE.

Function
REQ-015 Single shared 16x16 multiplier, product registered one cycle, SHALL compute 32x32->64 over four partial products.
REQ-016 FSM states: IDLE, ISSUE, DRAIN, RESP.
REQ-017 req_ready SHALL equal (state==IDLE); accept on req_valid&&req_ready; operands and sign flags latched at accept.
REQ-018 IDLE->ISSUE on accept; 2-bit issue index cleared to 0, accumulator cleared to 0.
REQ-019 ISSUE order, one per cycle: idx0 A[15:0]xB[15:0] unsigned; idx1 A[15:0]xB[31:16], signb=src2_signed; idx2 A[31:16]xB[15:0], signa=src1_signed; idx3 A[31:16]xB[31:16], both flags.
REQ-020 ISSUE->DRAIN after idx3 issued; DRAIN->RESP after one cycle.
REQ-021 Accumulate in cycle after each issue: idx0 zero-extended; idx1/idx2 sign-extended per their flag then <<16; idx3 <<32; 64-bit sum, carries beyond bit 63 discarded.
REQ-022 Latency: accept at edge T0 -> rsp_valid high in cycle T6; min initiation interval 7 cycles.
REQ-023 RESP: rsp_valid=1, rsp_result stable until rsp_ready; RESP->IDLE on rsp_ready.
REQ-024 rsp_valid SHALL be 0 in all states except RESP; rsp_result holds last accumulator value otherwise.
REQ-025 flush in ISSUE/DRAIN/RESP SHALL force IDLE next cycle, drop response, no rsp_valid; flush in IDLE ignored, request accepted that cycle if valid.
REQ-026 flush and rsp_ready together in RESP: result counts as consumed; next state IDLE.
REQ-027 req_valid outside IDLE SHALL be ignored, no queuing.

Reset
REQ-028 On reset: state IDLE, issue index 0, accumulator 0, rsp_result 0, rsp_valid 0, busy 0, req_ready 1 in the following cycle.
REQ-029 reset SHALL take priority over flush and all handshakes; mid-operation reset discards the operation.
REQ-030 Multiplier product register SHALL clear on reset.

Structure
REQ-031 Shared package mul_seq_pkg SHALL hold state enum, issue-index type, OPND_W=32, HALF_W=16, PROD_W=64.
REQ-032 One sub-module mul16_cell: 16x16 multiplier, signa/signb, one registered output, sync reset, enable.
REQ-033 FSM, index counter, operand-half mux and accumulator SHALL reside in mul_sequencer.

Verification
REQ-034 Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> rsp_result 0xFFFFFFFE00000001 at T6.
REQ-035 Signed 0x80000000 x signed 0x80000000 -> 0x4000000000000000; signed 0xFFFFFFFF x signed 0xFFFFFFFF -> 0x0000000000000001.
REQ-036 Signed 0xFFFFFFFF x unsigned 0x00000002 -> 0xFFFFFFFFFFFFFFFE.
REQ-037 rsp_ready low 3 cycles in RESP -> rsp_valid and result held, req_ready 0; back-to-back request accepted in the cycle after consumption.
REQ-038 flush asserted at T3 -> rsp_valid never asserted, req_ready 1 at T4; next request 3x5 -> 15.
REQ-039 reset at T2 -> busy 0, rsp_valid 0 at T3; subsequent 7x(-2) signed -> 0xFFFFFFFFFFFFFFF2.

Source files
------------

// File: rtl/mul_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_seq_pkg
// Description : Shared types and widths for the sequential 32x32 multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package mul_seq_pkg;

    localparam int OPND_W = 32;
    localparam int HALF_W = 16;
    localparam int PROD_W = 64;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    typedef logic [1:0] idx_t;

endpackage
`default_nettype wire

// File: rtl/mul_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : mul_sequencer_if
// Description : Request/response handshake bundle for mul_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface mul_sequencer_if;
    import mul_seq_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [OPND_W-1:0] req_src1;
    logic [OPND_W-1:0] req_src2;
    logic              req_src1_signed;
    logic              req_src2_signed;
    logic              flush;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [PROD_W-1:0] rsp_result;
    logic              busy;

    modport slave (
        input  req_valid, req_src1, req_src2, req_src1_signed, req_src2_signed,
        input  flush, rsp_ready,
        output req_ready, rsp_valid, rsp_result, busy
    );

    modport master (
        output req_valid, req_src1, req_src2, req_src1_signed, req_src2_signed,
        output flush, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, busy
    );

endinterface
`default_nettype wire

// File: rtl/mul16_cell.sv
`default_nettype none
// ============================================================================
// Module      : mul16_cell
// Description : 16x16 multiplier with per-operand sign control, registered out.
// Revision    : 1.0 - initial release
// ============================================================================
module mul16_cell
    import mul_seq_pkg::*;
(
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                i_en,
    input  wire logic                i_signa,
    input  wire logic                i_signb,
    input  wire logic [HALF_W-1:0]   i_a,
    input  wire logic [HALF_W-1:0]   i_b,
    output logic      [2*HALF_W-1:0] o_prod
);

    logic [2*HALF_W-1:0] w_a_ext;
    logic [2*HALF_W-1:0] w_b_ext;
    logic [2*HALF_W-1:0] w_prod;

    // Extending to 32 bits makes the truncated product exact for every
    // signed/unsigned combination of two 16-bit halves.
    assign w_a_ext = {{HALF_W{i_signa & i_a[HALF_W-1]}}, i_a};
    assign w_b_ext = {{HALF_W{i_signb & i_b[HALF_W-1]}}, i_b};
    assign w_prod  = w_a_ext * w_b_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            o_prod <= '0;
        end else if (i_en) begin
            o_prod <= w_prod;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mul_sequencer
// Description : 32x32->64 multiplier built from four passes of a 16x16 cell.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_sequencer
    import mul_seq_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        reset,
    mul_sequencer_if.slave   bus
);

    state_t              r_state;
    state_t              w_state_nxt;
    idx_t                r_idx;
    idx_t                w_pidx;
    logic [OPND_W-1:0]   r_src1;
    logic [OPND_W-1:0]   r_src2;
    logic                r_src1_signed;
    logic                r_src2_signed;
    logic [PROD_W-1:0]   r_acc;
    logic [PROD_W-1:0]   w_addend;
    logic                w_accept;
    logic                w_acc_en;
    logic [HALF_W-1:0]   w_a_half;
    logic [HALF_W-1:0]   w_b_half;
    logic [2*HALF_W-1:0] w_prod;

    assign w_accept = (r_state == S_IDLE) && bus.req_valid;

    // Index bit 1 selects the A half, bit 0 the B half.
    assign w_a_half = r_idx[1] ? r_src1[OPND_W-1:HALF_W] : r_src1[HALF_W-1:0];
    assign w_b_half = r_idx[0] ? r_src2[OPND_W-1:HALF_W] : r_src2[HALF_W-1:0];

    mul16_cell u_cell (
        .clk     (clk),
        .rst     (reset),
        .i_en    (r_state == S_ISSUE),
        .i_signa (r_idx[1] & r_src1_signed),
        .i_signb (r_idx[0] & r_src2_signed),
        .i_a     (w_a_half),
        .i_b     (w_b_half),
        .o_prod  (w_prod)
    );

    // The product register holds the partial issued one cycle earlier.
    assign w_acc_en = ((r_state == S_ISSUE) && (r_idx != 2'd0)) || (r_state == S_DRAIN);
    assign w_pidx   = (r_state == S_DRAIN) ? idx_t'(2'd3) : idx_t'(r_idx - 2'd1);

    always_comb begin
        w_addend = '0;
        case (w_pidx)
            2'd0:    w_addend = {32'd0, w_prod};
            2'd1:    w_addend = {{16{r_src2_signed & w_prod[31]}}, w_prod, 16'd0};
            2'd2:    w_addend = {{16{r_src1_signed & w_prod[31]}}, w_prod, 16'd0};
            default: w_addend = {w_prod, 32'd0};
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.req_valid) w_state_nxt = S_ISSUE;
            S_ISSUE: if (bus.flush) w_state_nxt = S_IDLE;
                     else if (r_idx == 2'd3) w_state_nxt = S_DRAIN;
            S_DRAIN: w_state_nxt = bus.flush ? S_IDLE : S_RESP;
            S_RESP:  if (bus.flush || bus.rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_acc         <= '0;
            r_src1        <= '0;
            r_src2        <= '0;
            r_src1_signed <= 1'b0;
            r_src2_signed <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_src1        <= bus.req_src1;
                r_src2        <= bus.req_src2;
                r_src1_signed <= bus.req_src1_signed;
                r_src2_signed <= bus.req_src2_signed;
                r_idx         <= '0;
                r_acc         <= '0;
            end else begin
                if (r_state == S_ISSUE) r_idx <= r_idx + 2'd1;
                if (w_acc_en)           r_acc <= r_acc + w_addend;
            end
        end
    end

    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.rsp_valid  = (r_state == S_RESP);
    assign bus.rsp_result = r_acc;

endmodule
`default_nettype wire
